// File: rtl/fpu_issue.sv
// fpu_issue: issues one FP operation at a time to an external FPU and writes
// the result back to the register file.
//   clk, rstn                       : clock, asynchronous active-low reset
//   req_valid/req_ctl/req_x1/x2/rd  : op presented by the pipeline
//   flush                           : squash the op currently being handled
//   stall                           : hold the upstream pipeline
//   fpu_en/fpu_ctl/fpu_x1/fpu_x2    : FPU start strobe, op code and operands
//   fpu_ready/fpu_y                 : FPU completion and result
//   wb_valid/wb_rd/wb_data          : one-cycle writeback
//   err                             : sticky watchdog flag
// Optional feature: define FPU_ISSUE_TIMEOUT_EN to enable a WAIT watchdog of
// TIMEOUT cycles; without it WAIT lasts until fpu_ready and err is tied 0.
module fpu_issue #(
    parameter int unsigned TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        req_valid,
    input  logic [3:0]  req_ctl,
    input  logic [31:0] req_x1,
    input  logic [31:0] req_x2,
    input  logic [4:0]  req_rd,
    input  logic        flush,
    output logic        stall,
    output logic        fpu_en,
    output logic [3:0]  fpu_ctl,
    output logic [31:0] fpu_x1,
    output logic [31:0] fpu_x2,
    input  logic        fpu_ready,
    input  logic [31:0] fpu_y,
    output logic        wb_valid,
    output logic [4:0]  wb_rd,
    output logic [31:0] wb_data,
    output logic        err
);

    localparam int unsigned CTL_W  = 4;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned RD_W   = 5;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_DONE  = 2'd3
    } state_e;

    state_e              state_q, state_d;
    logic [CTL_W-1:0]    ctl_q, ctl_d;
    logic [DATA_W-1:0]   x1_q, x1_d;
    logic [DATA_W-1:0]   x2_q, x2_d;
    logic [RD_W-1:0]     rd_q, rd_d;
    logic                fpu_en_q, fpu_en_d;
    logic                wb_valid_q, wb_valid_d;
    logic [RD_W-1:0]     wb_rd_q, wb_rd_d;
    logic [DATA_W-1:0]   wb_data_q, wb_data_d;
    logic                drop_q, drop_d;
    logic                drop_c;

`ifdef FPU_ISSUE_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [DATA_W-1:0] QNAN = 32'h7FC0_0000;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                err_q, err_d;
`endif

    // Next-state and register updates
    always_comb begin
        state_d    = state_q;
        ctl_d      = ctl_q;
        x1_d       = x1_q;
        x2_d       = x2_q;
        rd_d       = rd_q;
        fpu_en_d   = 1'b0;
        wb_valid_d = 1'b0;
        wb_rd_d    = wb_rd_q;
        wb_data_d  = wb_data_q;
        drop_d     = drop_q;
        // A flush in the completing cycle drops the result as well
        drop_c     = drop_q | flush;
`ifdef FPU_ISSUE_TIMEOUT_EN
        cnt_d      = cnt_q;
        err_d      = err_q;
`endif
        case (state_q)
            S_IDLE: begin
                drop_d = 1'b0;
                if (req_valid && !flush) begin
                    ctl_d    = req_ctl;
                    x1_d     = req_x1;
                    x2_d     = req_x2;
                    rd_d     = req_rd;
                    fpu_en_d = 1'b1;
                    state_d  = S_ISSUE;
                end
            end
            S_ISSUE: begin
                // fpu_ready here belongs to an older op and is ignored
                if (flush) drop_d = 1'b1;
`ifdef FPU_ISSUE_TIMEOUT_EN
                cnt_d = '0;
`endif
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (flush) drop_d = 1'b1;
                if (fpu_ready) begin
                    state_d = S_DONE;
                    if (!drop_c) begin
                        wb_valid_d = 1'b1;
                        wb_rd_d    = rd_q;
                        wb_data_d  = fpu_y;
                    end
                end
`ifdef FPU_ISSUE_TIMEOUT_EN
                else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    state_d = S_DONE;
                    err_d   = 1'b1;
                    if (!drop_c) begin
                        wb_valid_d = 1'b1;
                        wb_rd_d    = rd_q;
                        wb_data_d  = QNAN;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
`endif
            end
            S_DONE: begin
                drop_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and output registers
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= S_IDLE;
            ctl_q      <= '0;
            x1_q       <= '0;
            x2_q       <= '0;
            rd_q       <= '0;
            fpu_en_q   <= 1'b0;
            wb_valid_q <= 1'b0;
            wb_rd_q    <= '0;
            wb_data_q  <= '0;
            drop_q     <= 1'b0;
`ifdef FPU_ISSUE_TIMEOUT_EN
            cnt_q      <= '0;
            err_q      <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            ctl_q      <= ctl_d;
            x1_q       <= x1_d;
            x2_q       <= x2_d;
            rd_q       <= rd_d;
            fpu_en_q   <= fpu_en_d;
            wb_valid_q <= wb_valid_d;
            wb_rd_q    <= wb_rd_d;
            wb_data_q  <= wb_data_d;
            drop_q     <= drop_d;
`ifdef FPU_ISSUE_TIMEOUT_EN
            cnt_q      <= cnt_d;
            err_q      <= err_d;
`endif
        end
    end

    // stall is combinational so an IDLE request is held in the same cycle
    assign stall    = (state_q == S_ISSUE) || (state_q == S_WAIT) ||
                      ((state_q == S_IDLE) && req_valid);
    assign fpu_en   = fpu_en_q;
    assign fpu_ctl  = ctl_q;
    assign fpu_x1   = x1_q;
    assign fpu_x2   = x2_q;
    assign wb_valid = wb_valid_q;
    assign wb_rd    = wb_rd_q;
    assign wb_data  = wb_data_q;

`ifdef FPU_ISSUE_TIMEOUT_EN
    assign err = err_q;
`else
    // No watchdog: TIMEOUT has no effect and err never sets
    assign err = 1'b0 & (TIMEOUT != 0);
`endif

endmodule

// File: tb/tb_fpu_issue.sv
// Randomized bench for fpu_issue. The bench plays both the pipeline and the
// FPU; a writeback queue built from the op list is the reference for what
// must come out of wb_*, and per-cycle expectations follow the op lifecycle.
module tb_fpu_issue;

    localparam int NOPS = 40;

    logic        clk = 1'b0;
    logic        rstn;
    logic        req_valid;
    logic [3:0]  req_ctl;
    logic [31:0] req_x1, req_x2;
    logic [4:0]  req_rd;
    logic        flush;
    logic        stall;
    logic        fpu_en;
    logic [3:0]  fpu_ctl;
    logic [31:0] fpu_x1, fpu_x2;
    logic        fpu_ready;
    logic [31:0] fpu_y;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        err;

    always #5 clk = ~clk;

    fpu_issue #(.TIMEOUT(8)) dut (
        .clk(clk), .rstn(rstn), .req_valid(req_valid), .req_ctl(req_ctl),
        .req_x1(req_x1), .req_x2(req_x2), .req_rd(req_rd), .flush(flush),
        .stall(stall), .fpu_en(fpu_en), .fpu_ctl(fpu_ctl), .fpu_x1(fpu_x1),
        .fpu_x2(fpu_x2), .fpu_ready(fpu_ready), .fpu_y(fpu_y),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data), .err(err)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Op list: flush mode 0 none, 1 in ISSUE, 2 first WAIT cycle, 3 with ready
    logic [3:0]  op_ctl   [NOPS];
    logic [31:0] op_x1    [NOPS];
    logic [31:0] op_x2    [NOPS];
    logic [4:0]  op_rd    [NOPS];
    logic [31:0] op_y     [NOPS];
    int          op_dly   [NOPS];
    int          op_fm    [NOPS];
    bit          op_stale [NOPS];
    bit          op_iflush[NOPS];
    bit          op_chain [NOPS];

    // Reference: writebacks still owed, plus last visible writeback and err
    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
    } wb_t;
    wb_t         exp_q[$];
    logic [31:0] last_data = '0;
    logic        err_exp   = 1'b0;
    bit          mon_en    = 1'b0;

    // Every wb_valid pulse must match the oldest owed writeback
    always @(negedge clk) begin
        if (mon_en && rstn && wb_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                check_eq("wb_unexpected", 32'(wb_valid), 32'd0);
            end else begin
                wb_t e;
                e = exp_q.pop_front();
                check_eq("wb_rd", 32'(wb_rd), 32'(e.rd));
                check_eq("wb_data", wb_data, e.data);
            end
        end
    end

    task automatic drive_req(input int i);
        req_valid = 1'b1;
        req_ctl   = op_ctl[i];
        req_x1    = op_x1[i];
        req_x2    = op_x2[i];
        req_rd    = op_rd[i];
    endtask

    task automatic check_held(input string tag, input int i);
        check_eq({tag, "_ctl"}, 32'(fpu_ctl), 32'(op_ctl[i]));
        check_eq({tag, "_x1"}, fpu_x1, op_x1[i]);
        check_eq({tag, "_x2"}, fpu_x2, op_x2[i]);
    endtask

    // One op from an IDLE negedge until the IDLE negedge after DONE
    task automatic run_op(input int i);
        bit flushed;
        check_eq("idle_fpu_en", 32'(fpu_en), 32'd0);
        check_eq("idle_wb_valid", 32'(wb_valid), 32'd0);
        check_eq("idle_stall", 32'(stall), 32'(req_valid));
        drive_req(i);
        if (op_iflush[i]) begin
            flush = 1'b1;
            @(negedge clk);
            check_eq("iflush_no_issue", 32'(fpu_en), 32'd0);
            check_eq("iflush_stall", 32'(stall), 32'd1);
            flush = 1'b0;
        end
        #1 check_eq("req_stall", 32'(stall), 32'd1);
        @(negedge clk);
        // ISSUE
        check_eq("issue_en", 32'(fpu_en), 32'd1);
        check_eq("issue_stall", 32'(stall), 32'd1);
        check_eq("issue_wb_valid", 32'(wb_valid), 32'd0);
        check_held("issue", i);
        if (op_chain[i] && i + 1 < NOPS) drive_req(i + 1);
        else begin
            req_valid = 1'b0;
            req_ctl = 4'($urandom); req_x1 = $urandom; req_x2 = $urandom; req_rd = 5'($urandom);
        end
        if (op_stale[i]) begin
            fpu_ready = 1'b1;
            fpu_y     = ~op_y[i];
        end
        flush   = (op_fm[i] == 1);
        flushed = (op_fm[i] != 0);
        @(negedge clk);
        // WAIT
        for (int c = 0; c <= op_dly[i]; c++) begin
            check_eq("wait_en", 32'(fpu_en), 32'd0);
            check_eq("wait_stall", 32'(stall), 32'd1);
            check_eq("wait_wb_valid", 32'(wb_valid), 32'd0);
            check_held("wait", i);
            fpu_ready = 1'b0;
            flush     = (op_fm[i] == 2) && (c == 0);
            if (c == op_dly[i]) begin
                fpu_ready = 1'b1;
                fpu_y     = op_y[i];
                if (op_fm[i] == 3) flush = 1'b1;
                if (!flushed) begin
                    exp_q.push_back('{rd: op_rd[i], data: op_y[i]});
                    last_data = op_y[i];
                end
            end
            @(negedge clk);
        end
        // DONE
        fpu_ready = 1'b0;
        flush     = 1'b0;
        check_eq("done_wb_valid", 32'(wb_valid), 32'(!flushed));
        check_eq("done_stall", 32'(stall), 32'd0);
        check_eq("done_err", 32'(err), 32'(err_exp));
        check_eq("done_wb_data_hold", wb_data, last_data);
        @(negedge clk);
    endtask

    initial begin
        rstn = 1'b0; req_valid = 1'b0; req_ctl = '0; req_x1 = '0; req_x2 = '0;
        req_rd = '0; flush = 1'b0; fpu_ready = 1'b0; fpu_y = '0;

        // Directed ops first, random afterwards
        for (int i = 0; i < NOPS; i++) begin
            op_ctl[i]    = 4'($urandom);
            op_x1[i]     = $urandom;
            op_x2[i]     = $urandom;
            op_rd[i]     = 5'($urandom);
            op_y[i]      = $urandom;
            op_dly[i]    = $urandom_range(0, 5);
            op_fm[i]     = ($urandom_range(0, 9) < 6) ? 0 : $urandom_range(1, 3);
            op_stale[i]  = 1'($urandom);
            op_iflush[i] = ($urandom_range(0, 7) == 0);
            op_chain[i]  = (i < NOPS - 1) && 1'($urandom);
        end
        for (int i = 0; i < 8; i++) begin
            op_fm[i] = 0; op_stale[i] = 1'b0; op_iflush[i] = 1'b0; op_chain[i] = 1'b0;
        end
        op_ctl[0] = 4'd2; op_x1[0] = 32'h3F80_0000; op_x2[0] = 32'h4000_0000;
        op_rd[0] = 5'd5; op_y[0] = 32'h4040_0000; op_dly[0] = 1;
        op_stale[1] = 1'b1; op_y[1] = 32'h1234_5678; op_dly[1] = 2;
        op_fm[2] = 2; op_dly[2] = 3;
        op_fm[4] = 3;
        op_chain[5] = 1'b1; op_rd[5] = 5'd7; op_rd[6] = 5'd11;
        op_iflush[7] = 1'b1;

        repeat (3) @(negedge clk);
        check_eq("rst_fpu_en", 32'(fpu_en), 32'd0);
        check_eq("rst_wb_valid", 32'(wb_valid), 32'd0);
        check_eq("rst_wb_data", wb_data, 32'd0);
        check_eq("rst_wb_rd", 32'(wb_rd), 32'd0);
        check_eq("rst_err", 32'(err), 32'd0);
        check_eq("rst_stall", 32'(stall), 32'd0);
        check_eq("rst_fpu_x1", fpu_x1, 32'd0);
        rstn   = 1'b1;
        mon_en = 1'b1;
        @(negedge clk);

        for (int i = 0; i < NOPS; i++) begin
            run_op(i);
            if (!op_chain[i]) begin
                repeat ($urandom_range(0, 2)) begin
                    check_eq("gap_stall", 32'(stall), 32'd0);
                    check_eq("gap_wb_valid", 32'(wb_valid), 32'd0);
                    @(negedge clk);
                end
            end
        end

        // Reset in WAIT abandons the op; a late fpu_ready must do nothing
        drive_req(0);
        @(negedge clk);
        req_valid = 1'b0;
        repeat (2) @(negedge clk);
        #2 rstn = 1'b0;
        #1;
        check_eq("midrst_fpu_en", 32'(fpu_en), 32'd0);
        check_eq("midrst_wb_valid", 32'(wb_valid), 32'd0);
        check_eq("midrst_wb_data", wb_data, 32'd0);
        check_eq("midrst_wb_rd", 32'(wb_rd), 32'd0);
        check_eq("midrst_ctl", 32'(fpu_ctl), 32'd0);
        check_eq("midrst_x2", fpu_x2, 32'd0);
        check_eq("midrst_stall", 32'(stall), 32'd0);
        last_data = '0;
        @(negedge clk);
        rstn = 1'b1;
        fpu_ready = 1'b1; fpu_y = 32'hDEAD_BEEF;
        @(negedge clk);
        fpu_ready = 1'b0;
        repeat (3) begin
            check_eq("postrst_wb_valid", 32'(wb_valid), 32'd0);
            check_eq("postrst_fpu_en", 32'(fpu_en), 32'd0);
            check_eq("postrst_wb_data", wb_data, 32'd0);
            @(negedge clk);
        end
        req_valid = 1'b1; flush = 1'b1;
        #1 check_eq("postrst_stall_valid", 32'(stall), 32'd1);
        @(negedge clk);
        req_valid = 1'b0; flush = 1'b0;
        #1 check_eq("postrst_stall_idle", 32'(stall), 32'd0);
        @(negedge clk);

`ifdef FPU_ISSUE_TIMEOUT_EN
        // Watchdog: FPU never answers, writeback of the canonical NaN
        drive_req(3);
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        for (int c = 0; c < 8; c++) begin
            check_eq("wd_wait_stall", 32'(stall), 32'd1);
            check_eq("wd_wait_wb_valid", 32'(wb_valid), 32'd0);
            check_eq("wd_wait_err", 32'(err), 32'd0);
            if (c == 7) exp_q.push_back('{rd: op_rd[3], data: 32'h7FC0_0000});
            @(negedge clk);
        end
        check_eq("wd_wb_valid", 32'(wb_valid), 32'd1);
        check_eq("wd_err", 32'(err), 32'd1);
        last_data = 32'h7FC0_0000;
        err_exp   = 1'b1;
        @(negedge clk);
        check_eq("wd_err_sticky", 32'(err), 32'd1);
        run_op(0);
        check_eq("wd_err_still", 32'(err), 32'd1);
`endif

        check_eq("sb_drained", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/fpu_issue.md
FPU_ISSUE -- requirements
Module: fpu_issue

Interface
REQ-001 SHALL have parameter TIMEOUT, default 64, cycles allowed in WAIT before watchdog fires (used only with FPU_ISSUE_TIMEOUT_EN).
REQ-002 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-003 SHALL have port rstn  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port req_valid  input  1  pipeline presents an FP op.
REQ-005 SHALL have port req_ctl  input  4  FPU op code (2 = fadd).
REQ-006 SHALL have ports req_x1, req_x2  input  32 each  operands.
REQ-007 SHALL have port req_rd  input  5  destination register.
REQ-008 SHALL have port flush  input  1  squash in-flight op.
REQ-009 SHALL have port stall  output  1  hold upstream pipeline.
REQ-010 SHALL have ports fpu_en  output  1 and fpu_ctl  output  4  FPU start strobe and op.
REQ-011 SHALL have ports fpu_x1, fpu_x2  output  32 each  FPU operands.
REQ-012 SHALL have ports fpu_ready  input  1 and fpu_y  input  32  FPU completion and result.
REQ-013 SHALL have ports wb_valid  output  1, wb_rd  output  5, wb_data  output  32  writeback.
REQ-014 SHALL have port err  output  1  sticky watchdog flag.

Function
REQ-015 SHALL implement FSM states IDLE, ISSUE, WAIT, DONE.
REQ-016 In IDLE, req_valid=1 and flush=0 SHALL latch req_ctl/x1/x2/rd into holding registers and go to ISSUE.
REQ-017 In ISSUE, fpu_en SHALL be 1 for exactly that one cycle; next state WAIT.
REQ-018 fpu_ctl/fpu_x1/fpu_x2 SHALL drive the held values from ISSUE until leaving WAIT; stable throughout.
REQ-019 fpu_ready SHALL be ignored in ISSUE (stale from a prior op).
REQ-020 In WAIT, fpu_ready=1 SHALL capture fpu_y into wb_data and go to DONE; minimum accept-to-writeback latency 3 cycles.
REQ-021 In DONE, wb_valid SHALL be 1 for exactly one cycle with wb_rd = held rd; then IDLE.
REQ-022 wb_valid SHALL be 0 in all other states; wb_data/wb_rd hold last value.
REQ-023 stall SHALL be 1 in ISSUE and WAIT, and in IDLE combinationally when req_valid=1; 0 in DONE.
REQ-024 A new request SHALL be accepted in DONE? No: DONE always returns to IDLE; back-to-back ops spaced ≥1 IDLE cycle.
REQ-025 flush in IDLE SHALL block acceptance of a simultaneous req_valid.
REQ-026 flush in ISSUE or WAIT SHALL set a drop flag; fpu_en still completes; FSM still waits for fpu_ready; DONE then issues no wb_valid.
REQ-027 flush coincident with fpu_ready in WAIT SHALL drop the result.
REQ-028 Drop flag SHALL clear on entry to IDLE.

Reset
REQ-029 rstn=0 SHALL asynchronously force state IDLE, fpu_en=0, wb_valid=0, err=0, drop=0, watchdog=0, all data/rd/ctl registers 0.
REQ-030 Reset mid-WAIT SHALL abandon the op; a later fpu_ready in IDLE SHALL be ignored.
REQ-031 stall after reset SHALL equal req_valid only.

Configuration
REQ-032 Macro FPU_ISSUE_TIMEOUT_EN defined: counter clears on WAIT entry, increments each WAIT cycle; on reaching TIMEOUT without fpu_ready, SHALL set err (sticky until reset), load wb_data=32'h7FC00000, go to DONE (wb_valid per drop flag).
REQ-033 Macro undefined: WAIT SHALL last indefinitely, no counter logic, err tied 0.

Verification
REQ-034 fadd: req_ctl=2, x1=32'h3F800000, x2=32'h40000000, rd=5; FPU ready 2 cycles after en with y=32'h40400000 -> one fpu_en pulse, wb_valid one cycle, wb_rd=5, wb_data=32'h40400000, stall low in DONE.
REQ-035 Stale fpu_ready=1 during ISSUE -> ignored; writeback uses later ready's fpu_y=32'h12345678.
REQ-036 flush asserted 1 cycle after fpu_en -> no wb_valid, FSM returns IDLE after fpu_ready, next op writes back normally.
REQ-037 rstn low during WAIT then fpu_ready pulse in IDLE -> wb_valid stays 0, all outputs 0.
REQ-038 FPU_ISSUE_TIMEOUT_EN, TIMEOUT=8, fpu_ready never asserted -> after 8 WAIT cycles err=1, wb_valid one cycle with wb_data=32'h7FC00000; err stays 1.
REQ-039 Two back-to-back requests held on req_valid -> two fpu_en pulses, two wb_valid pulses in order with correct rd values.
